fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Producer side of the F/D pipeline register: owns the PC and issues word reads to a
//  multi-cycle instruction memory over a req/ready handshake. Drives the F/D register
//  with instruction, oldpc (PC of that instruction) and newpc (PC+2), plus a valid flag.
//  Honours decode-stage stall (one-entry skid buffer) and branch flush/redirect.
//  Enters HALT when it fetches an HLT opcode.
// PARAMETERS
//  RESET_PC    16'h0000  PC value loaded on reset
//  NOP_INSTR   16'h0000  instruction driven to F/D when the slot is invalid
//  HLT_OPCODE  4'hF      instr[15:12] value that halts fetch
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   synchronous, active-low reset
//  stall       in   1   decode cannot accept; hold F/D outputs
//  flush       in   1   branch taken; redirect PC to branch_pc
//  branch_pc   in   16  redirect target (bit 0 ignored, forced 0)
//  imem_req    out  1   read request, level
//  imem_addr   out  16  read address, stable while imem_req=1 and imem_ready=0
//  imem_ready  in   1   transfer completes on edge where imem_req&imem_ready
//  imem_data   in   16  read data, valid when imem_ready=1
//  instr_out   out  16  instruction to F/D
//  oldpc_out   out  16  PC of instr_out
//  newpc_out   out  16  oldpc_out+2
//  valid_out   out  1   instr_out is a real fetched instruction
//  halted      out  1   HLT fetched, fetch stopped
// BEHAVIOUR
//  Reset (rst=0 at edge): pc=RESET_PC, state=RUN, buf_valid=0, instr_out=NOP_INSTR,
//   oldpc_out=newpc_out=16'h0000, valid_out=0, halted=0, imem_req=0 that cycle.
//   Applies mid-transfer; an in-flight request is abandoned (imem resets with us).
//  States RUN / DRAIN / HALT. imem_addr=pc in RUN; the held in-flight address in DRAIN.
//  RUN: imem_req=1 unless buf_valid=1 or halted.
//   Accept (req&ready, no flush): if stall=0 -> instr_out<=imem_data,
//   oldpc_out<=pc, newpc_out<=pc+2, valid_out<=1. If stall=1 -> capture the same
//   triple into skid buffer, buf_valid<=1, outputs held. Either way pc<=pc+2.
//   No accept, stall=0, buf_valid=0: valid_out<=0, instr_out<=NOP_INSTR.
//   stall=0 with buf_valid=1: outputs<=buffer, valid_out<=1, buf_valid<=0; req resumes next cycle.
//   stall=1, nothing accepted: all outputs and buffer held.
//  HLT: accepted word with [15:12]==HLT_OPCODE is delivered normally (or buffered),
//   then state<=HALT; imem_req=0 from next cycle; halted=1. Outputs then go NOP/valid 0
//   once consumed (stall=0).
//  Flush (highest priority, overrides stall and accept): pc<=branch_pc&16'hFFFE,
//   buf_valid<=0, instr_out<=NOP_INSTR, valid_out<=0, halted<=0.
//   If imem_req=1 and imem_ready=0 at that edge -> state<=DRAIN (else RUN).
//  DRAIN: keep imem_req=1 at old address; on ready discard data, state<=RUN, fetch new pc
//   next cycle. A second flush during DRAIN only updates pc.
//  Arithmetic: pc+2 modulo 2^16 (16'hFFFE -> 16'h0000); no wrap flag.
//  Fetch bandwidth: max one instruction per ready; ready may come in the request cycle
//   (zero-wait memory gives 1 instr/cycle).
// TESTING
//  1 Reset, zero-wait imem returns 16'h1234,16'h5678 -> outputs (1234,0000,0002,v=1)
//    then (5678,0002,0004,v=1); no bubbles.
//  2 3-wait-state imem -> imem_addr stable for 4 cycles, valid_out=0 during waits,
//    one instr per 4 cycles.
//  3 stall=1 for 3 cycles while ready arrives -> outputs unchanged, word buffered,
//    imem_req=0; stall drop -> buffered word out next edge, pc correct, none lost or duplicated.
//  4 flush branch_pc=16'h0041 mid-wait -> pc=0040, DRAIN discards old data,
//    next imem_addr=0040; flush+stall same cycle -> flush wins, valid_out=0.
//  5 fetch 16'hF000 -> delivered with valid_out=1, halted=1, imem_req=0 thereafter;
//    later flush to 0x0100 -> halted=0, fetch resumes at 0x0100.
//  6 pc=16'hFFFE fetch -> newpc_out=16'h0000, next imem_addr=0000; rst=0 mid-DRAIN ->
//    all reset values next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to a multi-cycle instruction memory and
// feeds the F/D register, with a one-entry skid buffer for decode stalls.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] oldpc_out,
    output logic [15:0] newpc_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] drain_addr;
    logic        buf_valid;
    logic [15:0] buf_instr, buf_oldpc, buf_newpc;
    logic        accept;

    assign pc_plus2 = pc + 16'd2;
    assign accept   = imem_req && imem_ready && (state == RUN);

    // NOTE: sync reset lives inside the clocked process; sequential state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (flush) begin
            // A request still waiting on memory must be drained before a new address goes out.
            state_next = (imem_req && !imem_ready) ? DRAIN : RUN;
        end else begin
            case (state)
                RUN:     if (accept && imem_data[15:12] == HLT_OPCODE) state_next = HALT;
                DRAIN:   if (imem_ready) state_next = RUN;
                HALT:    state_next = HALT;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        imem_req  = rst && (((state == RUN) && !buf_valid) || (state == DRAIN));
        imem_addr = (state == DRAIN) ? drain_addr : pc;
        halted    = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            instr_out <= NOP_INSTR;
            oldpc_out <= 16'h0000;
            newpc_out <= 16'h0000;
            valid_out <= 1'b0;
        end else if (flush) begin
            pc        <= branch_pc & 16'hFFFE;
            buf_valid <= 1'b0;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (accept) begin
            pc <= pc_plus2;
            if (!stall) begin
                instr_out <= imem_data;
                oldpc_out <= pc;
                newpc_out <= pc_plus2;
                valid_out <= 1'b1;
            end else begin
                buf_valid <= 1'b1;
            end
        end else if (!stall) begin
            if (buf_valid) begin
                instr_out <= buf_instr;
                oldpc_out <= buf_oldpc;
                newpc_out <= buf_newpc;
                valid_out <= 1'b1;
                buf_valid <= 1'b0;
            end else begin
                instr_out <= NOP_INSTR;
                valid_out <= 1'b0;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only ever read when qualified by buf_valid / DRAIN.
    always_ff @(posedge clk) begin
        if (accept && stall && !flush) begin
            buf_instr <= imem_data;
            buf_oldpc <= pc;
            buf_newpc <= pc_plus2;
        end
        if (flush && state == RUN) drain_addr <= pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory handshake is driven cycle by cycle with
// hand-computed expectations for the F/D outputs and the request port.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, imem_ready;
    logic [15:0] branch_pc, imem_data;
    logic        imem_req, valid_out, halted;
    logic [15:0] imem_addr, instr_out, oldpc_out, newpc_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_pc(branch_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .instr_out(instr_out), .oldpc_out(oldpc_out),
        .newpc_out(newpc_out), .valid_out(valid_out), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        branch_pc = 16'h0000; imem_data = 16'h0000;
        step();
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h0000, 16'h0000, 16'h0000, 1'b0})
            $display("FAIL reset_outs: got %h %h %h %b", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if ({imem_req, halted} !== 2'b00) $display("FAIL reset_req_halt: got req=%b halted=%b exp 0 0", imem_req, halted);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) $display("FAIL reset_first_req: got req=%b addr=%h exp 1 0000", imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        imem_ready = 1'b1; imem_data = 16'h1234;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h1234, 16'h0000, 16'h0002, 1'b1})
            $display("FAIL zw_first: got %h %h %h %b exp 1234 0000 0002 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 16'h0002) $display("FAIL zw_addr: got %h exp 0002", imem_addr);
        else pass_cnt++;
        imem_data = 16'h5678;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h5678, 16'h0002, 16'h0004, 1'b1})
            $display("FAIL zw_second: got %h %h %h %b exp 5678 0002 0004 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        imem_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        // Three wait cycles then ready on the fourth: address must not move.
        for (int i = 0; i < 4; i++) begin
            imem_ready = (i == 3);
            imem_data  = (i == 3) ? 16'hAAAA : 16'hEEEE;
            total_cnt++;
            if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) $display("FAIL ws_addr%0d: got req=%b addr=%h exp 1 0004", i, imem_req, imem_addr);
            else pass_cnt++;
            step();
            if (i < 3) begin
                total_cnt++;
                if ({instr_out, valid_out} !== {16'h0000, 1'b0}) $display("FAIL ws_bubble%0d: got %h v=%b exp 0000 v=0", i, instr_out, valid_out);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'hAAAA, 16'h0004, 16'h0006, 1'b1})
            $display("FAIL ws_deliver: got %h %h %h %b exp aaaa 0004 0006 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        imem_ready = 1'b0;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i > 0);
            imem_data  = (i == 1) ? 16'hBBBB : 16'hCCCC;
            step();
            total_cnt++;
            if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'hAAAA, 16'h0004, 16'h0006, 1'b1})
                $display("FAIL st_hold%0d: got %h %h %h %b exp aaaa 0004 0006 1", i, instr_out, oldpc_out, newpc_out, valid_out);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (imem_req !== 1'b0) $display("FAIL st_req%0d: got %b exp 0", i, imem_req);
                else pass_cnt++;
            end
        end
        stall = 1'b0; imem_ready = 1'b0;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'hBBBB, 16'h0006, 16'h0008, 1'b1})
            $display("FAIL st_unbuf: got %h %h %h %b exp bbbb 0006 0008 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0008}) $display("FAIL st_resume: got req=%b addr=%h exp 1 0008", imem_req, imem_addr);
        else pass_cnt++;
        imem_ready = 1'b1; imem_data = 16'hCCCC;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'hCCCC, 16'h0008, 16'h000A, 1'b1})
            $display("FAIL st_next: got %h %h %h %b exp cccc 0008 000a 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        imem_ready = 1'b0;
    endtask

    task automatic test_flush();
        step();
        flush = 1'b1; branch_pc = 16'h0041;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h000A}) $display("FAIL fl_drain: got v=%b req=%b addr=%h exp 0 1 000a", valid_out, imem_req, imem_addr);
        else pass_cnt++;
        step();
        imem_ready = 1'b1; imem_data = 16'hDEAD;
        step();
        imem_ready = 1'b0;
        total_cnt++;
        if ({instr_out, valid_out} !== {16'h0000, 1'b0}) $display("FAIL fl_discard: got %h v=%b exp 0000 v=0", instr_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) $display("FAIL fl_target: got req=%b addr=%h exp 1 0040", imem_req, imem_addr);
        else pass_cnt++;
        imem_ready = 1'b1; imem_data = 16'h1111;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h1111, 16'h0040, 16'h0042, 1'b1})
            $display("FAIL fl_fetch: got %h %h %h %b exp 1111 0040 0042 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        flush = 1'b1; stall = 1'b1; branch_pc = 16'h0080; imem_data = 16'h2222;
        step();
        flush = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        total_cnt++;
        if ({instr_out, valid_out} !== {16'h0000, 1'b0}) $display("FAIL fl_stall_wins: got %h v=%b exp 0000 v=0", instr_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0080}) $display("FAIL fl_stall_addr: got req=%b addr=%h exp 1 0080", imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        imem_ready = 1'b1; imem_data = 16'hF000;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out, halted, imem_req} !== {16'hF000, 16'h0080, 16'h0082, 1'b1, 1'b1, 1'b0})
            $display("FAIL hlt_deliver: got %h %h %h v=%b h=%b req=%b", instr_out, oldpc_out, newpc_out, valid_out, halted, imem_req);
        else pass_cnt++;
        imem_data = 16'h1234;
        step();
        total_cnt++;
        if ({valid_out, halted, imem_req} !== 3'b010) $display("FAIL hlt_idle: got v=%b h=%b req=%b exp 0 1 0", valid_out, halted, imem_req);
        else pass_cnt++;
        imem_ready = 1'b0; flush = 1'b1; branch_pc = 16'h0100;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0100}) $display("FAIL hlt_restart: got h=%b req=%b addr=%h exp 0 1 0100", halted, imem_req, imem_addr);
        else pass_cnt++;
        imem_ready = 1'b1; imem_data = 16'h3333;
        step();
        imem_ready = 1'b0;
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h3333, 16'h0100, 16'h0102, 1'b1})
            $display("FAIL hlt_resume: got %h %h %h %b exp 3333 0100 0102 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_reset();
        flush = 1'b1; branch_pc = 16'hFFFF; imem_ready = 1'b1; imem_data = 16'h9999;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({valid_out, imem_addr} !== {1'b0, 16'hFFFE}) $display("FAIL wr_target: got v=%b addr=%h exp 0 fffe", valid_out, imem_addr);
        else pass_cnt++;
        imem_data = 16'h4444;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h4444, 16'hFFFE, 16'h0000, 1'b1})
            $display("FAIL wr_newpc: got %h %h %h %b exp 4444 fffe 0000 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 16'h0000) $display("FAIL wr_addr: got %h exp 0000", imem_addr);
        else pass_cnt++;
        imem_data = 16'h5555;
        step();
        imem_ready = 1'b0; flush = 1'b1; branch_pc = 16'h0200;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) $display("FAIL rd_drain: got req=%b addr=%h exp 1 0002", imem_req, imem_addr);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out, halted, imem_req} !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL rd_reset: got %h %h %h v=%b h=%b req=%b", instr_out, oldpc_out, newpc_out, valid_out, halted, imem_req);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) $display("FAIL rd_addr: got req=%b addr=%h exp 1 0000", imem_req, imem_addr);
        else pass_cnt++;
        imem_ready = 1'b1; imem_data = 16'h6666;
        step();
        imem_ready = 1'b0;
        total_cnt++;
        if ({instr_out, oldpc_out, newpc_out, valid_out} !== {16'h6666, 16'h0000, 16'h0002, 1'b1})
            $display("FAIL rd_run: got %h %h %h %b exp 6666 0000 0002 1", instr_out, oldpc_out, newpc_out, valid_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush();
        test_halt();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
